core_regfile_mp: RTL and testbench

//  Parametrised two-bank register file (bank 0 = integer, bank 1 = float) with NRD synchronous read ports.

---
 rtl/core_regfile_mp.sv | 121 ++++++++++++
 tb/tb_core_regfile_mp.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_regfile_mp.sv
// Two-bank (int/float) register file, NRD sync read ports, busy scoreboard, byte insert.
// Ports: CLK/RST_N; WE/WBANK/WADDR/WDATA write; INE/INADDR/INDATA insert; ALLOC/ABANK/AADDR
// busy-set; RE/RADDR -> RDATA/RBUSY (1-cycle latency). Macro CORE_REGFILE_BYPASS_EN: write-to-read bypass.
module core_regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 4,
  localparam int AW  = $clog2(NREG),
  localparam int RW  = 1 + AW
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic              WBANK,
  input  logic [AW-1:0]     WADDR,
  input  logic [XLEN-1:0]   WDATA,
  input  logic              INE,
  input  logic [AW-1:0]     INADDR,
  input  logic [7:0]        INDATA,
  input  logic              ALLOC,
  input  logic              ABANK,
  input  logic [AW-1:0]     AADDR,
  input  logic [NRD-1:0]    RE,
  input  logic [NRD*RW-1:0] RADDR,
  output logic [NRD*XLEN-1:0] RDATA,
  output logic [NRD-1:0]    RBUSY
);

  localparam int NENT = 2 * NREG;

  // Flat storage indexed by {bank,index}; key 0 is int r0.
  logic [XLEN-1:0] mem [NENT];
  logic [NENT-1:0] busy;
  logic [NENT-1:0] busy_nxt;

  logic [RW-1:0]   wkey;
  logic [RW-1:0]   ikey;
  logic [RW-1:0]   akey;
  logic            we_ok;
  logic            in_ok;
  logic            al_ok;
  logic [XLEN-1:0] ins_val;

  logic [RW-1:0]   rkey    [NRD];
  logic [XLEN-1:0] rd_val  [NRD];
  logic [NRD-1:0]  rb_val;
  logic [XLEN-1:0] rdata_q [NRD];
  logic [NRD-1:0]  rbusy_q;

  assign wkey = {WBANK, WADDR};
  assign ikey = {1'b0, INADDR};
  assign akey = {ABANK, AADDR};

  // Int r0 absorbs every update.
  assign we_ok = WE && (wkey != '0);
  // A full-word write to the same reg overrides the insert.
  assign in_ok = INE && (INADDR != '0)
              && !(we_ok && (wkey == ikey));
  assign al_ok = ALLOC && (akey != '0);

  assign ins_val = {mem[ikey][XLEN-1:8], INDATA};

  // Allocation applied last: a new producer wins over a completing one.
  always_comb begin
    busy_nxt = busy;
    if (we_ok) busy_nxt[wkey] = 1'b0;
    if (in_ok) busy_nxt[ikey] = 1'b0;
    if (al_ok) busy_nxt[akey] = 1'b1;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    assign rkey[p] = RADDR[p*RW +: RW];
    assign RDATA[p*XLEN +: XLEN] = rdata_q[p];
  end

  assign RBUSY = rbusy_q;

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_val[p] = mem[rkey[p]];
      rb_val[p] = busy[rkey[p]];
`ifdef CORE_REGFILE_BYPASS_EN
      if (we_ok && (rkey[p] == wkey)) begin
        rd_val[p] = WDATA;
        rb_val[p] = 1'b0;
      end else if (in_ok && (rkey[p] == ikey)) begin
        rd_val[p] = ins_val;
        rb_val[p] = 1'b0;
      end
`endif
      if (rkey[p] == '0) begin
        rd_val[p] = '0;
        rb_val[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NENT; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
      for (int p = 0; p < NRD; p++) begin
        rdata_q[p] <= '0;
      end
      rbusy_q <= '0;
    end else begin
      if (we_ok) mem[wkey] <= WDATA;
      if (in_ok) mem[ikey] <= ins_val;
      busy <= busy_nxt;
      for (int p = 0; p < NRD; p++) begin
        if (RE[p]) begin
          rdata_q[p] <= rd_val[p];
          rbusy_q[p] <= rb_val[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_core_regfile_mp.sv
// Testbench for core_regfile_mp: directed vectors, literal checks
// plus a per-cycle compare against a bank/array model.
module tb_core_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int AW   = 5;
  localparam int RW   = 6;
`ifdef CORE_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N;
  logic WE, WBANK, INE, ALLOC, ABANK;
  logic [AW-1:0] WADDR, INADDR, AADDR;
  logic [XLEN-1:0] WDATA;
  logic [7:0] INDATA;
  logic [NRD-1:0] RE;
  logic [NRD*RW-1:0] RADDR;
  logic [NRD*XLEN-1:0] RDATA;
  logic [NRD-1:0] RBUSY;

  always #5 CLK = ~CLK;

  core_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .WE(WE), .WBANK(WBANK), .WADDR(WADDR), .WDATA(WDATA),
    .INE(INE), .INADDR(INADDR), .INDATA(INDATA),
    .ALLOC(ALLOC), .ABANK(ABANK), .AADDR(AADDR),
    .RE(RE), .RADDR(RADDR), .RDATA(RDATA), .RBUSY(RBUSY)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m  [2][NREG];
  logic        bz [2][NREG];
  logic [31:0] exp_d [NRD];
  logic        exp_b [NRD];
  logic [31:0] nx_d  [NRD];
  logic        nx_b  [NRD];

  function automatic logic [31:0] dport(int p);
    return RDATA[p*XLEN +: XLEN];
  endfunction

  // Applies the rules for the upcoming edge to the model.
  task automatic model_step();
    logic [31:0] nm [2][NREG];
    logic        nb [2][NREG];
    logic        hit [2][NREG];
    int b, i;
    nx_d = exp_d;
    nx_b = exp_b;
    if (!RST_N) begin
      for (int k = 0; k < NREG; k++) begin
        m[0][k] = 0; m[1][k] = 0; bz[0][k] = 0; bz[1][k] = 0;
      end
      for (int p = 0; p < NRD; p++) begin
        nx_d[p] = 0; nx_b[p] = 0;
      end
      return;
    end
    nm = m;
    nb = bz;
    for (int k = 0; k < NREG; k++) begin
      hit[0][k] = 0; hit[1][k] = 0;
    end
    if (INE && INADDR != 0) begin
      nm[0][INADDR][7:0] = INDATA;
      nb[0][INADDR] = 0;
      hit[0][INADDR] = 1;
    end
    if (WE && !(WBANK == 0 && WADDR == 0)) begin
      nm[WBANK][WADDR] = WDATA;
      nb[WBANK][WADDR] = 0;
      hit[WBANK][WADDR] = 1;
    end
    if (ALLOC && !(ABANK == 0 && AADDR == 0))
      nb[ABANK][AADDR] = 1;
    for (int p = 0; p < NRD; p++) begin
      if (RE[p]) begin
        b = int'(RADDR[p*RW + AW]);
        i = int'(RADDR[p*RW +: AW]);
        if (BYP && hit[b][i]) begin
          nx_d[p] = nm[b][i]; nx_b[p] = 0;
        end else begin
          nx_d[p] = m[b][i]; nx_b[p] = bz[b][i];
        end
      end
    end
    m = nm;
    bz = nb;
  endtask

  task automatic compare_all();
    for (int p = 0; p < NRD; p++) begin
      checks++;
      if (dport(p) !== exp_d[p] || RBUSY[p] !== exp_b[p]) begin
        failures++;
        $display("FAIL model_port%0d got data=%h busy=%b want data=%h busy=%b",
                 p, dport(p), RBUSY[p], exp_d[p], exp_b[p]);
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    exp_d = nx_d;
    exp_b = nx_b;
    if (cmp_en) compare_all();
    WE = 0; INE = 0; ALLOC = 0; RE = '0;
  endtask

  task automatic wr(logic b, int a, logic [31:0] d);
    WE = 1; WBANK = b; WADDR = AW'(a); WDATA = d;
  endtask

  task automatic ins(int a, logic [7:0] d);
    INE = 1; INADDR = AW'(a); INDATA = d;
  endtask

  task automatic alc(logic b, int a);
    ALLOC = 1; ABANK = b; AADDR = AW'(a);
  endtask

  task automatic rd(int p, logic b, int a);
    RE[p] = 1'b1;
    RADDR[p*RW +: RW] = {b, AW'(a)};
  endtask

  initial begin
    RST_N = 0;
    WE = 0; WBANK = 0; WADDR = '0; WDATA = '0;
    INE = 0; INADDR = '0; INDATA = '0;
    ALLOC = 0; ABANK = 0; AADDR = '0;
    RE = '0; RADDR = '0;
    for (int p = 0; p < NRD; p++) begin
      exp_d[p] = 0; exp_b[p] = 0;
    end
    tick();
    tick();
    RST_N = 1;
    cmp_en = 1;
    chk("reset_rdata", RDATA[31:0], 32'h0);
    chk("reset_rbusy", {28'h0, RBUSY}, 32'h0);

    // T1 reset clears contents
    wr(0, 5, 32'hDEADBEEF); tick();
    rd(0, 0, 5); tick();
    chk("t1_pre", dport(0), 32'hDEADBEEF);
    RST_N = 0; tick();
    RST_N = 1;
    for (int p = 0; p < NRD; p++) rd(p, 0, 5);
    tick();
    chk("t1_data3", dport(3), 32'h0);
    chk("t1_busy", {28'h0, RBUSY}, 32'h0);

    // T2 r0 hardwired, f0 ordinary
    wr(0, 0, 32'h1234); tick();
    wr(1, 0, 32'h3F800000); tick();
    rd(0, 0, 0); rd(1, 1, 0); tick();
    chk("t2_r0", dport(0), 32'h0);
    chk("t2_f0", dport(1), 32'h3F800000);

    // T3 scoreboard
    alc(0, 7); tick();
    rd(0, 0, 7); tick();
    chk("t3_busy", {31'h0, RBUSY[0]}, 32'h1);
    wr(0, 7, 32'h55); tick();
    rd(0, 0, 7); tick();
    chk("t3_data", dport(0), 32'h55);
    chk("t3_free", {31'h0, RBUSY[0]}, 32'h0);
    alc(0, 7); wr(0, 7, 32'h66); tick();
    rd(0, 0, 7); tick();
    chk("t3_alloc_we_busy", {31'h0, RBUSY[0]}, 32'h1);
    chk("t3_alloc_we_data", dport(0), 32'h66);
    alc(0, 12); rd(1, 0, 12); tick();
    chk("t3_alloc_rd_pre", {31'h0, RBUSY[1]}, 32'h0);
    rd(1, 0, 12); tick();
    chk("t3_alloc_rd_post", {31'h0, RBUSY[1]}, 32'h1);
    alc(0, 0); tick();
    rd(2, 0, 0); tick();
    chk("t3_r0_busy", {31'h0, RBUSY[2]}, 32'h0);

    // T4 insert
    wr(0, 3, 32'hAABBCCDD); tick();
    ins(3, 8'h7E); tick();
    rd(0, 0, 3); tick();
    chk("t4_insert", dport(0), 32'hAABBCC7E);
    wr(0, 3, 32'h1); ins(3, 8'hFF); tick();
    rd(0, 0, 3); tick();
    chk("t4_we_wins", dport(0), 32'h00000001);
    wr(0, 4, 32'h44); ins(6, 8'hA5); tick();
    rd(0, 0, 4); rd(1, 0, 6); tick();
    chk("t4_both_we", dport(0), 32'h44);
    chk("t4_both_ins", dport(1), 32'h000000A5);

    // T5 read during write
    wr(0, 9, 32'h11); tick();
    wr(1, 9, 32'h99); tick();
    alc(0, 9); tick();
    wr(0, 9, 32'h22); rd(0, 0, 9); rd(1, 1, 9); tick();
    chk("t5_rdw_data", dport(0), BYP ? 32'h22 : 32'h11);
    chk("t5_rdw_busy", {31'h0, RBUSY[0]}, BYP ? 32'h0 : 32'h1);
    chk("t5_f9", dport(1), 32'h99);
    rd(0, 0, 9); tick();
    chk("t5_after", dport(0), 32'h22);

    // T6 hold and multiport
    wr(0, 1, 32'hA1); tick();
    wr(0, 2, 32'hA2); tick();
    wr(1, 1, 32'hB1); tick();
    wr(1, 2, 32'hB2); tick();
    rd(0, 0, 1); rd(1, 0, 2); rd(2, 1, 1); rd(3, 1, 2); tick();
    chk("t6_p0", dport(0), 32'hA1);
    chk("t6_p3", dport(3), 32'hB2);
    wr(0, 1, 32'hC1); tick();
    wr(1, 2, 32'hD2); tick();
    chk("t6_hold_p0", dport(0), 32'hA1);
    chk("t6_hold_p3", dport(3), 32'hB2);
    RE = 4'b1111; tick();
    chk("t6_new_p0", dport(0), 32'hC1);
    chk("t6_new_p1", dport(1), 32'hA2);
    chk("t6_new_p3", dport(3), 32'hD2);
    for (int p = 0; p < NRD; p++) rd(p, 1, 1);
    tick();
    chk("t6_same_p2", dport(2), 32'hB1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
